// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields, resolves
// EX/MEM and MEM/WB forwarding, selects shamt/immediate, and detects load-use hazards.
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [5:0]  id_ALUFun,
  input  logic        id_Sign,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm16,
  input  logic [4:0]  id_shamt,
  input  logic        id_ALUSrc1,
  input  logic        id_ALUSrc2,
  input  logic        id_ExtOp,
  input  logic        id_LuiOp,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_MemToReg,
  input  logic        exm_RegWrite,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_RegWrite,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_data,
  input  logic        stall_in,
  input  logic        flush,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_MemToReg,
  output logic [31:0] ex_store_data,
  output logic        hz_stall
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [5:0]  alu_fun;
    logic        sign;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic        alu_src1;
    logic        alu_src2;
    logic        ext_op;
    logic        lui_op;
  } ex_reg_t;

  ex_reg_t     ex_q;
  ex_reg_t     id_fields;
  logic        bubble;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [31:0] imm;

  // Control flags of an empty decode slot are zeroed on capture so EX never
  // sees a write/load from a non-instruction.
  always_comb begin
    id_fields            = '0;
    id_fields.valid      = id_valid;
    id_fields.reg_write  = id_valid & id_RegWrite;
    id_fields.mem_read   = id_valid & id_MemRead;
    id_fields.mem_write  = id_valid & id_MemWrite;
    id_fields.mem_to_reg = id_valid & id_MemToReg;
    id_fields.rd         = id_rd_addr;
    id_fields.alu_fun    = id_ALUFun;
    id_fields.sign       = id_Sign;
    id_fields.rs_addr    = id_rs_addr;
    id_fields.rt_addr    = id_rt_addr;
    id_fields.rs_data    = id_rs_data;
    id_fields.rt_data    = id_rt_data;
    id_fields.imm16      = id_imm16;
    id_fields.shamt      = id_shamt;
    id_fields.alu_src1   = id_ALUSrc1;
    id_fields.alu_src2   = id_ALUSrc2;
    id_fields.ext_op     = id_ExtOp;
    id_fields.lui_op     = id_LuiOp;
  end

  // Conservative: both source fields are compared even if the op ignores rt.
  assign hz_stall = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == id_rs_addr) | (ex_q.rd == id_rt_addr));

  // Flush beats hold; hold beats a hazard bubble.
  assign bubble = flush | (~stall_in & hz_stall);

  // NOTE: every EX register, data included, is reset so outputs are defined
  // out of reset; non-blocking assignments keep all fields updating together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (bubble) begin
      ex_q.valid      <= 1'b0;
      ex_q.reg_write  <= 1'b0;
      ex_q.mem_read   <= 1'b0;
      ex_q.mem_write  <= 1'b0;
      ex_q.mem_to_reg <= 1'b0;
    end else if (!stall_in) begin
      ex_q <= id_fields;
    end
  end

  // NOTE: each always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    if (exm_RegWrite && exm_rd != 5'd0 && exm_rd == ex_q.rs_addr)
      fwd_rs = exm_result;
    else if (mwb_RegWrite && mwb_rd != 5'd0 && mwb_rd == ex_q.rs_addr)
      fwd_rs = mwb_data;

    fwd_rt = ex_q.rt_data;
    if (exm_RegWrite && exm_rd != 5'd0 && exm_rd == ex_q.rt_addr)
      fwd_rt = exm_result;
    else if (mwb_RegWrite && mwb_rd != 5'd0 && mwb_rd == ex_q.rt_addr)
      fwd_rt = mwb_data;

    if (ex_q.lui_op)
      imm = {ex_q.imm16, 16'h0};
    else if (ex_q.ext_op)
      imm = {{16{ex_q.imm16[15]}}, ex_q.imm16};
    else
      imm = {16'h0, ex_q.imm16};
  end

  assign A             = ex_q.alu_src1 ? {27'h0, ex_q.shamt} : fwd_rs;
  assign B             = ex_q.alu_src2 ? imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ALUFun        = ex_q.alu_fun;
  assign Sign          = ex_q.sign;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_RegWrite   = ex_q.reg_write;
  assign ex_MemRead    = ex_q.mem_read;
  assign ex_MemWrite   = ex_q.mem_write;
  assign ex_MemToReg   = ex_q.mem_to_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus random
// traffic compared against an instruction-level reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_Sign, id_ALUSrc1, id_ALUSrc2, id_ExtOp, id_LuiOp;
  logic [5:0]  id_ALUFun;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm16;
  logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg;
  logic        exm_RegWrite, mwb_RegWrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_data;
  logic        stall_in, flush;
  logic [31:0] A, B, ex_store_data;
  logic [5:0]  ALUFun;
  logic        Sign, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, hz_stall;
  logic [4:0]  ex_rd;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ALUFun(id_ALUFun), .id_Sign(id_Sign),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16), .id_shamt(id_shamt),
    .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2), .id_ExtOp(id_ExtOp), .id_LuiOp(id_LuiOp),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemToReg(id_MemToReg), .exm_RegWrite(exm_RegWrite), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_RegWrite(mwb_RegWrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .stall_in(stall_in), .flush(flush), .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg), .ex_store_data(ex_store_data),
    .hz_stall(hz_stall)
  );

  always #5 clk = ~clk;

  // The instruction the model believes occupies EX.
  typedef struct {
    bit        valid, rw, mr, mw, m2r, sign, src1, src2, ext, lui;
    bit [4:0]  rd, rs_addr, rt_addr, shamt;
    bit [5:0]  fun;
    bit [31:0] rs_data, rt_data;
    bit [15:0] imm16;
  } instr_t;

  instr_t m;

  function automatic instr_t empty_instr();
    instr_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic bit ref_hz();
    return id_valid && m.valid && m.mr && m.rd != 0 &&
           (m.rd == id_rs_addr || m.rd == id_rt_addr);
  endfunction

  function automatic bit [31:0] ref_fwd(bit [4:0] addr, bit [31:0] regval);
    if (exm_RegWrite && exm_rd != 0 && exm_rd == addr) return exm_result;
    if (mwb_RegWrite && mwb_rd != 0 && mwb_rd == addr) return mwb_data;
    return regval;
  endfunction

  function automatic bit [31:0] ref_imm(instr_t i);
    bit [31:0] z;
    z = 32'(i.imm16);
    if (i.lui) return z * 32'd65536;
    if (i.ext && i.imm16 >= 16'h8000) return z + 32'hFFFF0000;
    return z;
  endfunction

  // Next EX content given the current decode inputs and control, in rule order.
  function automatic instr_t model_next();
    instr_t n;
    n = m;
    if (flush) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
    end else if (stall_in) begin
      n = m;
    end else if (ref_hz()) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
    end else begin
      n.valid = id_valid;
      n.rw = id_valid && id_RegWrite;   n.mr  = id_valid && id_MemRead;
      n.mw = id_valid && id_MemWrite;   n.m2r = id_valid && id_MemToReg;
      n.rd = id_rd_addr;  n.fun = id_ALUFun;  n.sign = id_Sign;
      n.rs_addr = id_rs_addr;  n.rt_addr = id_rt_addr;
      n.rs_data = id_rs_data;  n.rt_data = id_rt_data;
      n.imm16 = id_imm16;  n.shamt = id_shamt;
      n.src1 = id_ALUSrc1;  n.src2 = id_ALUSrc2;  n.ext = id_ExtOp;  n.lui = id_LuiOp;
    end
    return n;
  endfunction

  task automatic tick();
    instr_t n;
    n = model_next();
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_ALUFun = 0; id_Sign = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm16 = 0; id_shamt = 0; id_ALUSrc1 = 0; id_ALUSrc2 = 0;
    id_ExtOp = 0; id_LuiOp = 0; id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_MemToReg = 0;
    exm_RegWrite = 0; exm_rd = 0; exm_result = 0; mwb_RegWrite = 0; mwb_rd = 0; mwb_data = 0;
    stall_in = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    m = empty_instr();
    #12;
    chk_cnt++; if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ex_valid); else pass_cnt++;
    chk_cnt++; if (ex_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", ex_rd); else pass_cnt++;
    chk_cnt++; if ({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg}); else pass_cnt++;
    chk_cnt++; if ({ALUFun, Sign} !== 7'd0) $display("FAIL reset_fun: got %h want 0", {ALUFun, Sign}); else pass_cnt++;
    chk_cnt++; if ({A, B} !== 64'd0) $display("FAIL reset_ab: got %h want 0", {A, B}); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1;
    id_valid = 1; id_rd_addr = 6; id_RegWrite = 1; id_rs_addr = 2; id_rs_data = 32'h00001234;
    tick();
    chk_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) $display("FAIL reset_first_instr: valid=%b rd=%0d want 1/6", ex_valid, ex_rd); else pass_cnt++;
    chk_cnt++; if (A !== 32'h00001234) $display("FAIL reset_first_a: got %h want 00001234", A); else pass_cnt++;
    stall_in = 1;
    tick();
    #2 rst_n = 0;
    #1;
    m = empty_instr();
    chk_cnt++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_rd !== 5'd0)
      $display("FAIL reset_mid_stall: valid=%b rw=%b rd=%0d want 0/0/0", ex_valid, ex_RegWrite, ex_rd); else pass_cnt++;
    chk_cnt++; if (A !== 32'd0) $display("FAIL reset_mid_stall_a: got %h want 0", A); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    id_valid = 1; id_rs_addr = 5; id_rs_data = 32'h11111111; id_rd_addr = 1;
    tick();
    exm_RegWrite = 1; exm_rd = 5; exm_result = 32'hAAAAAAAA;
    mwb_RegWrite = 1; mwb_rd = 5; mwb_data = 32'hBBBBBBBB;
    #1;
    chk_cnt++; if (A !== 32'hAAAAAAAA) $display("FAIL fwd_exm_priority: got %h want AAAAAAAA", A); else pass_cnt++;
    exm_RegWrite = 0;
    #1;
    chk_cnt++; if (A !== 32'hBBBBBBBB) $display("FAIL fwd_mwb: got %h want BBBBBBBB", A); else pass_cnt++;
    exm_RegWrite = 1; exm_rd = 0; mwb_rd = 0;
    #1;
    chk_cnt++; if (A !== 32'h11111111) $display("FAIL fwd_r0_excluded: got %h want 11111111", A); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_immediates();
    clear_inputs();
    id_valid = 1; id_imm16 = 16'h8001; id_ALUSrc2 = 1; id_ExtOp = 1;
    tick();
    chk_cnt++; if (B !== 32'hFFFF8001) $display("FAIL imm_sext: got %h want FFFF8001", B); else pass_cnt++;
    id_ExtOp = 0;
    tick();
    chk_cnt++; if (B !== 32'h00008001) $display("FAIL imm_zext: got %h want 00008001", B); else pass_cnt++;
    id_LuiOp = 1; id_ExtOp = 1;
    tick();
    chk_cnt++; if (B !== 32'h80010000) $display("FAIL imm_lui: got %h want 80010000", B); else pass_cnt++;
    id_ALUSrc1 = 1; id_shamt = 31; id_rs_data = 32'hFFFFFFFF;
    tick();
    chk_cnt++; if (A !== 32'h0000001F) $display("FAIL shamt_a: got %h want 0000001F", A); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    tick();
    id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_MemToReg = 1; id_rd_addr = 8;
    id_rs_addr = 1; id_rt_addr = 2;
    tick();
    id_MemRead = 0; id_MemToReg = 0; id_rs_addr = 8; id_rt_addr = 9; id_rd_addr = 10;
    id_rs_data = 32'hDEAD0000;
    #1;
    chk_cnt++; if (hz_stall !== 1'b1) $display("FAIL lu_detect: got %b want 1", hz_stall); else pass_cnt++;
    stall_in = 1;
    tick();
    chk_cnt++; if (ex_MemRead !== 1'b1 || ex_rd !== 5'd8 || hz_stall !== 1'b1)
      $display("FAIL lu_hold_wins: mr=%b rd=%0d hz=%b want 1/8/1", ex_MemRead, ex_rd, hz_stall); else pass_cnt++;
    stall_in = 0;
    tick();
    chk_cnt++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0) $display("FAIL lu_bubble: valid=%b rw=%b want 0/0", ex_valid, ex_RegWrite); else pass_cnt++;
    chk_cnt++; if (hz_stall !== 1'b0) $display("FAIL lu_one_cycle: got %b want 0", hz_stall); else pass_cnt++;
    tick();
    mwb_RegWrite = 1; mwb_rd = 8; mwb_data = 32'h12345678;
    #1;
    chk_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10) $display("FAIL lu_dep_enter: valid=%b rd=%0d want 1/10", ex_valid, ex_rd); else pass_cnt++;
    chk_cnt++; if (A !== 32'h12345678) $display("FAIL lu_dep_fwd: got %h want 12345678", A); else pass_cnt++;
    clear_inputs();
    tick();
    id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_rd_addr = 0;
    tick();
    id_MemRead = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 10;
    #1;
    chk_cnt++; if (hz_stall !== 1'b0) $display("FAIL lu_r0_nostall: got %b want 0", hz_stall); else pass_cnt++;
    tick();
    chk_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10) $display("FAIL lu_r0_advance: valid=%b rd=%0d want 1/10", ex_valid, ex_rd); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    id_valid = 1; id_rd_addr = 3; id_RegWrite = 1; id_rs_addr = 4; id_rs_data = 32'h0BADF00D;
    id_ALUFun = 6'h21;
    tick();
    stall_in = 1;
    id_rd_addr = 7; id_rs_data = 32'h55555555; id_ALUFun = 6'h00; id_RegWrite = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cnt++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_RegWrite !== 1'b1)
        $display("FAIL stall_hold_ctl[%0d]: valid=%b rd=%0d rw=%b want 1/3/1", c, ex_valid, ex_rd, ex_RegWrite); else pass_cnt++;
      chk_cnt++; if (A !== 32'h0BADF00D || ALUFun !== 6'h21)
        $display("FAIL stall_hold_data[%0d]: A=%h fun=%h want 0BADF00D/21", c, A, ALUFun); else pass_cnt++;
    end
    flush = 1; id_RegWrite = 1;
    tick();
    chk_cnt++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0) $display("FAIL flush_beats_stall: valid=%b rw=%b want 0/0", ex_valid, ex_RegWrite); else pass_cnt++;
    flush = 0; stall_in = 0;
    id_valid = 0; id_RegWrite = 1; id_MemRead = 1; id_MemWrite = 1; id_MemToReg = 1;
    tick();
    chk_cnt++; if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg} !== 5'b0)
      $display("FAIL invalid_flags: got %b want 00000", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg}); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    bit [31:0] ea, eb, es;
    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 4) != 0);
      id_ALUFun = 6'($urandom); id_Sign = 1'($urandom);
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_rd_addr = 5'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom;
      id_imm16 = 16'($urandom); id_shamt = 5'($urandom);
      id_ALUSrc1 = ($urandom_range(0, 3) == 0); id_ALUSrc2 = 1'($urandom);
      id_ExtOp = 1'($urandom); id_LuiOp = ($urandom_range(0, 3) == 0);
      id_RegWrite = 1'($urandom); id_MemRead = ($urandom_range(0, 2) == 0);
      id_MemWrite = 1'($urandom); id_MemToReg = 1'($urandom);
      exm_RegWrite = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      mwb_RegWrite = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_data = $urandom;
      stall_in = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
      #1;
      ea = m.src1 ? 32'(m.shamt) : ref_fwd(m.rs_addr, m.rs_data);
      es = ref_fwd(m.rt_addr, m.rt_data);
      eb = m.src2 ? ref_imm(m) : es;
      chk_cnt++; if (A !== ea) $display("FAIL rnd_a[%0d]: got %h want %h", c, A, ea); else pass_cnt++;
      chk_cnt++; if (B !== eb) $display("FAIL rnd_b[%0d]: got %h want %h", c, B, eb); else pass_cnt++;
      chk_cnt++; if (ex_store_data !== es) $display("FAIL rnd_store[%0d]: got %h want %h", c, ex_store_data, es); else pass_cnt++;
      chk_cnt++; if (hz_stall !== ref_hz()) $display("FAIL rnd_hz[%0d]: got %b want %b", c, hz_stall, ref_hz()); else pass_cnt++;
      chk_cnt++; if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg} !== {m.valid, m.rw, m.mr, m.mw, m.m2r})
        $display("FAIL rnd_ctl[%0d]: got %b want %b", c, {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg},
                 {m.valid, m.rw, m.mr, m.mw, m.m2r}); else pass_cnt++;
      if (m.valid) begin
        chk_cnt++; if ({ex_rd, ALUFun, Sign} !== {m.rd, m.fun, m.sign})
          $display("FAIL rnd_fields[%0d]: got %h want %h", c, {ex_rd, ALUFun, Sign}, {m.rd, m.fun, m.sign}); else pass_cnt++;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d checks want completion", chk_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forwarding();
    test_immediates();
    test_load_use();
    test_stall_flush();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It registers decoded instruction fields from the decode stage and resolves operand forwarding from EX/MEM and MEM/WB. It applies shamt and immediate selection and presents final `A`, `B`, `ALUFun` and `Sign` to the ALU. It also detects load-use hazards and inserts bubbles, with stall and flush control.

## Interface
- No parameters (data width fixed at 32, register address 5).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_ALUFun` in 6: ALU function code.
- `id_Sign` in 1: signed compare select.
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr` in 5 each: source and destination register numbers.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_imm16` in 16: instruction immediate.
- `id_shamt` in 5: shift amount field.
- `id_ALUSrc1` in 1: when 1, A takes shamt.
- `id_ALUSrc2` in 1: when 1, B takes the immediate.
- `id_ExtOp` in 1: 1 selects sign-extend, 0 selects zero-extend.
- `id_LuiOp` in 1: immediate is `{imm16,16'h0}`.
- `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_MemToReg` in 1 each: control flags carried to later stages.
- `exm_RegWrite` in 1, `exm_rd` in 5, `exm_result` in 32: EX/MEM forwarding source.
- `mwb_RegWrite` in 1, `mwb_rd` in 5, `mwb_data` in 32: MEM/WB forwarding source.
- `stall_in` in 1: downstream hold.
- `flush` in 1: kill the instruction entering EX (branch or jump resolve).
- `A`, `B` out 32: ALU operands.
- `ALUFun` out 6, `Sign` out 1: registered passthrough to the ALU.
- `ex_valid` out 1; `ex_rd` out 5; `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemToReg` out 1 each.
- `ex_store_data` out 32: forwarded rt value for stores.
- `hz_stall` out 1: combinational; decode and PC must hold.

## Operation
- **Registered fields.** All `id_*` fields are captured into EX registers. The registered `rs`/`rt` data, addresses, imm16, shamt and Src/Ext/Lui flags are kept for the EX-side muxes.
- **Forwarding.** Applied in EX, combinationally from registered addresses and live forward inputs, separately for rs and rt.
  - If `exm_RegWrite`, `exm_rd != 0` and `exm_rd == addr`, use `exm_result`.
  - Else if `mwb_RegWrite`, `mwb_rd != 0` and `mwb_rd == addr`, use `mwb_data`.
  - Else use the registered data.
  - EX/MEM has priority. Register 0 is never forwarded.
- **Immediate.**
  - `LuiOp` gives `{imm16,16'h0}` and overrides `ExtOp`.
  - Otherwise `ExtOp` gives `{{16{imm16[15]}},imm16}`, else `{16'h0,imm16}`.
- **Operand select.**
  - `A = ALUSrc1 ? {27'h0,shamt} : fwd_rs`.
  - `B = ALUSrc2 ? imm : fwd_rt`.
  - `ex_store_data = fwd_rt` always.
- **Load-use hazard.** `hz_stall = id_valid & ex_valid & ex_MemRead & (ex_rd != 0) & ((ex_rd == id_rs_addr) | (ex_rd == id_rt_addr))`. The comparison is deliberately conservative: both sources are always checked.
- **Register update priority, per clock.**
  1. `flush`: load a bubble. `ex_valid` and all control flags go to 0; data fields are don't-care but held.
  2. `stall_in`: hold all EX registers unchanged.
  3. `hz_stall`: load a bubble as in `flush`.
  4. Otherwise load the `id_*` fields, with `ex_valid = id_valid`. If `id_valid = 0`, the control flags load as 0.
- **Outputs while invalid.** When `ex_valid = 0`, `A`, `B`, `ALUFun` and `Sign` still drive the registered values. Downstream relies only on the gated control flags.

## Timing
- **Reset.** On `rst_n` low, asynchronously and immediately: every EX register is 0. So `ex_valid=0`, `ex_rd=0`, all control flags 0, `ALUFun=6'b000000`, `Sign=0`. `A` and `B` are 0 unless a forward input matches address 0, which is impossible because r0 is excluded. Reset asserted mid-stall discards the held instruction.
- **Latency.** An instruction presented in decode at cycle N drives the ALU in cycle N+1. Forwarding is same-cycle with respect to `exm_*`/`mwb_*`.
- **Simultaneous events.**
  - `flush` with `stall_in`: flush wins.
  - `hz_stall` with `stall_in`: hold wins. `hz_stall` stays asserted, so decode also holds.
  - `flush` with `hz_stall`: bubble, same result either way.
- **Hazard sequence.** `hz_stall` holds exactly 1 cycle for a single load-use pair. The next cycle the load sits in MEM, EX carries a bubble, and the dependent instruction enters EX with its value taken from the MEM/WB path on the following cycle.

## Test plan
- **Reset.** Assert `rst_n=0` mid-traffic -> all outputs 0 within the same cycle. After release, the first `id_valid` instruction appears at EX one cycle later.
- **Forwarding priority.** rs=5 with `id_rs_data=0x11111111`, `exm_rd=5`/`exm_result=0xAAAAAAAA`, `mwb_rd=5`/`mwb_data=0xBBBBBBBB`, both RegWrite=1 -> `A=0xAAAAAAAA`. Drop `exm_RegWrite` -> `A=0xBBBBBBBB`. Set both rd to 0 -> `A=0x11111111`.
- **Immediates.** imm16=0x8001:
  - ExtOp=1 -> `B=0xFFFF8001`.
  - ExtOp=0 -> `B=0x00008001`.
  - LuiOp=1 -> `B=0x80010000`.
  - ALUSrc1=1 with shamt=31 -> `A=0x0000001F`.
- **Load-use.** `lw r8` in EX followed by `add` with rs=8 in decode -> `hz_stall=1` for 1 cycle. The next EX shows `ex_valid=0`, then `add` with `A` forwarded from `mwb_data`. Repeat with destination r0 -> no stall.
- **Stall and flush.**
  - `stall_in=1` for 3 cycles -> EX outputs unchanged.
  - `flush=1` together with `stall_in=1` -> `ex_valid=0` and `ex_RegWrite=0` next cycle.
  - `id_valid=0` -> control flags 0.
